// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Boot-time loader that sits in front of the single-cycle RISC-V core. It takes
// a byte stream over a valid/ready handshake, assembles little-endian 32-bit
// instruction words, and writes them into instruction memory. The core is held
// in reset until the whole program has been written.
//
// Stream format: count_lo, count_hi (16-bit word count N), then N*4 payload
// bytes, each word LSB first. With BOOT_CHECKSUM_EN defined, one checksum byte
// follows the payload. The 8-bit sum of all stream bytes, including the
// checksum byte, must be zero.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   in_data      stream byte
//   in_valid     in_data valid this cycle
//   in_ready     loader accepts a byte this cycle (registered)
//   imem_we      IMEM write strobe, one cycle per word
//   imem_addr    IMEM word address
//   imem_wdata   assembled instruction word
//   cpu_reset_n  core reset, low until the load completes
//   done         load completed (sticky)
//   error        load aborted (sticky)
//
// state   | meaning
// --------+--------------------------------------------------------------
// HDR_LO  | waiting for the low byte of the word count
// HDR_HI  | waiting for the high byte; range-check N
// LOAD    | assembling payload words and writing them to IMEM
// CHK     | waiting for the checksum byte (BOOT_CHECKSUM_EN only)
// DONE    | program loaded, core released; terminal until reset
// ERROR   | load aborted, core held in reset; terminal until reset
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int INST_WIDTH      = 32,
  parameter int IMEM_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0]      imem_wdata,
  output logic                       cpu_reset_n,
  output logic                       done,
  output logic                       error
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR_LO, S_HDR_HI, S_LOAD, S_CHK, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR_LO, S_HDR_HI, S_LOAD, S_DONE, S_ERROR
  } state_t;
`endif

  localparam logic [16:0] MAX_WORDS = 17'd1 << IMEM_ADDR_WIDTH;

  state_t                   state;
  logic [1:0]               byte_idx;
  logic [IMEM_ADDR_WIDTH:0] word_idx;
  logic [15:0]              count;
  logic [23:0]              asm_word;   // lanes 0..2; lane 3 comes straight from in_data

  logic        xfer;
  logic [15:0] hdr_count;
  logic [16:0] next_word;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign hdr_count = {in_data, count[7:0]};
  assign next_word = 17'(word_idx) + 17'd1;
  assign last_word = (next_word == {1'b0, count});

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_final;
  assign sum_final = sum + in_data;
`else
  // Set while the final word's write strobe is out; DONE follows one cycle later.
  logic last_wr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HDR_LO;
      byte_idx    <= 2'd0;
      word_idx    <= '0;
      count       <= 16'd0;
      asm_word    <= 24'd0;
      in_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum         <= 8'd0;
`else
      last_wr     <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR_LO: begin
          in_ready <= 1'b1;
          if (xfer) begin
            count[7:0] <= in_data;
`ifdef BOOT_CHECKSUM_EN
            sum        <= sum + in_data;
`endif
            state      <= S_HDR_HI;
          end
        end

        S_HDR_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
`ifdef BOOT_CHECKSUM_EN
            sum         <= sum + in_data;
`endif
            if (hdr_count == 16'd0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
              in_ready    <= 1'b0;
            end else if ({1'b0, hdr_count} > MAX_WORDS) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
`ifndef BOOT_CHECKSUM_EN
          if (last_wr) begin
            last_wr     <= 1'b0;
            state       <= S_DONE;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
            in_ready    <= 1'b0;
          end else
`endif
          if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
            sum      <= sum + in_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_word[7:0]   <= in_data;
              2'd1: asm_word[15:8]  <= in_data;
              2'd2: asm_word[23:16] <= in_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[IMEM_ADDR_WIDTH-1:0];
                imem_wdata <= {in_data, asm_word};
                word_idx   <= word_idx + 1'b1;
                if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                  state <= S_CHK;
`else
                  last_wr <= 1'b1;
`endif
                end
              end
            endcase
          end
        end

`ifdef BOOT_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (sum_final == 8'd0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          in_ready <= 1'b0;
        end

        S_ERROR: begin
          in_ready    <= 1'b0;
          cpu_reset_n <= 1'b0;
        end

        default: begin
          state    <= S_HDR_LO;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle RISCV core.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the assembled words into instruction memory.
- Holds the core in reset until the whole program has been written, then releases it.

Parameters:
- INST_WIDTH, 32, instruction word width; fixed at 32, i.e. 4 bytes per word.
- IMEM_ADDR_WIDTH, 8, IMEM word-address width; maximum program length is 2**IMEM_ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a transfer happens when in_valid && in_ready.
- imem_we  output  1  IMEM write strobe, one cycle per word.
- imem_addr  output  IMEM_ADDR_WIDTH  word address of the write.
- imem_wdata  output  INST_WIDTH  assembled instruction word.
- cpu_reset_n  output  1  reset to the core; low until load completes.
- done  output  1  load completed successfully; sticky.
- error  output  1  load aborted; sticky.

Behaviour:
- Reset (async, any state): state=HDR_LO; byte_idx=0, word_idx=0, count=0.
  - Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset_n=0, done=0, error=0.
  - in_ready rises in the first cycle after reset_n deasserts.
  - IMEM contents are never cleared by this block.
- Stream format: count_lo, count_hi (16-bit word count N, little endian), then N*4 payload bytes, each word LSB first.
- All outputs are registered.
- in_ready=1 in HDR_LO, HDR_HI and LOAD (and CHK when enabled); in_ready=0 in DONE and ERROR.
  - A byte presented while in_ready=0 is not consumed.
- in_valid may drop on any cycle; gaps must not cause duplicate or skipped bytes.
- States and transitions:
  - HDR_LO: on transfer, count[7:0]=in_data; go to HDR_HI.
  - HDR_HI: on transfer, count[15:8]=in_data, then:
    - if N==0 -> DONE;
    - else if N > 2**IMEM_ADDR_WIDTH -> ERROR;
    - else -> LOAD.
  - LOAD: each transfer shifts the byte into lane byte_idx (byte 0 -> bits 7:0); byte_idx increments and wraps 3->0.
    - The cycle after the 4th byte is accepted: imem_we=1 for exactly one cycle, imem_addr=word_idx, imem_wdata=assembled word.
    - word_idx then increments.
    - in_ready stays 1 during the write cycle, so assembly of the next word overlaps the write.
    - After the write of word N-1: go to DONE, or to CHK when the optional feature is enabled.
  - DONE: done=1, cpu_reset_n=1, both asserted the cycle after the final imem_we (or after the header for N==0). Terminal until reset.
  - ERROR: error=1, cpu_reset_n=0. Terminal until reset.
- Boundary conditions:
  - N == 2**IMEM_ADDR_WIDTH is legal; the last write uses imem_addr = all ones. word_idx is IMEM_ADDR_WIDTH+1 bits wide internally.
  - Reset mid-word or mid-header discards the partial word and count; the next stream starts again at HDR_LO.
  - done and error are never both 1.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - One extra byte follows the payload, accepted in state CHK.
  - The 8-bit modular sum of the header bytes, all payload bytes and the checksum byte must equal 0.
  - The CHK byte may be accepted as early as the cycle of the final imem_we.
  - The cycle after acceptance: match -> DONE, mismatch -> ERROR.
  - Words already written stay in IMEM, but cpu_reset_n stays 0 on ERROR.
- Undefined: no CHK state, no checksum logic; LOAD goes directly to DONE after the final write.

Test Plan:
1. Reset, send 00 00 -> no imem_we ever; done=1 and cpu_reset_n=1 one cycle after the 2nd byte; in_ready=0 thereafter.
2. Send 02 00 93 00 50 00 13 01 A0 00 at full rate -> exactly two imem_we pulses: (addr 0, 0x00500093), then (addr 1, 0x00A00113); done=1 one cycle after the 2nd write.
3. Same stream as test 2 with in_valid low every other cycle -> identical writes, no duplicate strobes, same final state.
4. IMEM_ADDR_WIDTH=8, header 01 01 (N=257) -> error=1 next cycle; in_ready=0; cpu_reset_n=0; no imem_we.
5. Start the test 2 stream, assert reset_n low after 2 payload bytes, then resend the full stream -> all outputs return to reset values; writes (0, 0x00500093) and (1, 0x00A00113) occur cleanly.
6. With BOOT_CHECKSUM_EN, append 0x67 to the test 2 stream -> done=1. Append 0x68 instead -> error=1, done=0, cpu_reset_n=0.
